// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch stage. Holds the PC, selects the next
// PC from PC+4 / branch-JAL target / JALR target, and registers the fetched
// instruction into the IF/ID pipeline register. Redirects from execute
// override hazard-unit stalls and squash the wrong-path fetch.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] ALUResultE,
  input  logic        StallF,
  input  logic        StallD,
  input  logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        MisalignF
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_id_q, instr_id_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] pc_plus4_id_q, pc_plus4_id_d;
  logic        valid_id_q, valid_id_d;
  logic        misalign_q, misalign_d;

  logic [31:0] pc_plus4_f;
  logic [31:0] pc_next_f;
  logic        redirect_e;

  // Next-PC selection; code 11 is reserved and falls through to PC+4.
  always_comb begin
    pc_plus4_f = pc_q + 32'd4;
    pc_next_f  = pc_plus4_f;
    redirect_e = 1'b0;
    case (PCSrcE)
      2'b01: begin
        pc_next_f  = PCTargetE;
        redirect_e = 1'b1;
      end
      2'b10: begin
        pc_next_f  = ALUResultE & 32'hFFFF_FFFE;
        redirect_e = 1'b1;
      end
      default: begin
        pc_next_f  = pc_plus4_f;
        redirect_e = 1'b0;
      end
    endcase
  end

  // PC and IF/ID next state: redirect beats stall, stall holds, else advance.
  always_comb begin
    pc_d          = pc_q;
    instr_id_d    = instr_id_q;
    pc_id_d       = pc_id_q;
    pc_plus4_id_d = pc_plus4_id_q;
    valid_id_d    = valid_id_q;
    misalign_d    = redirect_e && (pc_next_f[1:0] != 2'b00);

    if (redirect_e) begin
      pc_d = pc_next_f;
    end else if (!StallF) begin
      pc_d = pc_plus4_f;
    end

    if (redirect_e) begin
      instr_id_d    = NOP_INSTR;
      pc_id_d       = 32'd0;
      pc_plus4_id_d = 32'd0;
      valid_id_d    = 1'b0;
    end else if (!StallD) begin
      instr_id_d    = InstrF;
      pc_id_d       = pc_q;
      pc_plus4_id_d = pc_plus4_f;
      valid_id_d    = 1'b1;
    end
  end

  // State registers; asynchronous reset discards any pending redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      instr_id_q    <= NOP_INSTR;
      pc_id_q       <= 32'd0;
      pc_plus4_id_q <= 32'd0;
      valid_id_q    <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      instr_id_q    <= instr_id_d;
      pc_id_q       <= pc_id_d;
      pc_plus4_id_q <= pc_plus4_id_d;
      valid_id_q    <= valid_id_d;
      misalign_q    <= misalign_d;
    end
  end

  assign PCF       = pc_q;
  assign InstrD    = instr_id_q;
  assign PCD       = pc_id_q;
  assign PCPlus4D  = pc_plus4_id_q;
  assign ValidD    = valid_id_q;
  assign MisalignF = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed sequence for fetch_stage with a per-cycle
// expected-state queue and a few constant spot checks from the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int W = 130;

  logic        clk;
  logic        rst_n;
  logic [1:0]  pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] alu_result_e;
  logic        stall_f;
  logic        stall_d;
  logic [31:0] instr_f;
  logic [31:0] pcf;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        misalign_f;

  int total;
  int bad;

  // Expected {pcf, instr_d, pc_d, pc_plus4_d, valid_d, misalign_f}
  logic [W-1:0] exp_q[$];

  // Reference state of the stage.
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4d;
  logic        m_valid, m_mis;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .PCSrcE    (pc_src_e),
    .PCTargetE (pc_target_e),
    .ALUResultE(alu_result_e),
    .StallF    (stall_f),
    .StallD    (stall_d),
    .InstrF    (instr_f),
    .PCF       (pcf),
    .InstrD    (instr_d),
    .PCD       (pc_d),
    .PCPlus4D  (pc_plus4_d),
    .ValidD    (valid_d),
    .MisalignF (misalign_f)
  );

  // Instruction memory image: each word tags its own address.
  assign instr_f = 32'hAAAA_0000 | pcf;

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_instr = NOP;
    m_pcd   = 32'h0;
    m_pc4d  = 32'h0;
    m_valid = 1'b0;
    m_mis   = 1'b0;
  endtask

  // Drive one cycle of inputs, predict the state after the edge, then compare.
  task automatic cycle(input logic [1:0] src, input logic [31:0] tgt,
                       input logic [31:0] alu, input logic sf, input logic sd);
    logic [31:0] nxt;
    logic        redir;
    logic [W-1:0] e;
    pc_src_e     = src;
    pc_target_e  = tgt;
    alu_result_e = alu;
    stall_f      = sf;
    stall_d      = sd;
    redir = (src == 2'b01) || (src == 2'b10);
    nxt   = (src == 2'b01) ? tgt : (src == 2'b10) ? {alu[31:1], 1'b0} : m_pc + 32'd4;
    m_mis = redir && (nxt[1:0] != 2'b00);
    if (redir) begin
      m_instr = NOP; m_pcd = 32'h0; m_pc4d = 32'h0; m_valid = 1'b0;
    end else if (!sd) begin
      m_instr = 32'hAAAA_0000 | m_pc; m_pcd = m_pc; m_pc4d = m_pc + 32'd4; m_valid = 1'b1;
    end
    if (redir) m_pc = nxt;
    else if (!sf) m_pc = m_pc + 32'd4;
    exp_q.push_back({m_pc, m_instr, m_pcd, m_pc4d, m_valid, m_mis});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("sb_pcf",      pcf,                 e[129:98]);
    chk("sb_instr_d",  instr_d,             e[97:66]);
    chk("sb_pc_d",     pc_d,                e[65:34]);
    chk("sb_pc4_d",    pc_plus4_d,          e[33:2]);
    chk("sb_valid_d",  {31'd0, valid_d},    {31'd0, e[1]});
    chk("sb_misalign", {31'd0, misalign_f}, {31'd0, e[0]});
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pcf"},   pcf,                 32'h0);
    chk({tag, "_instr"}, instr_d,             NOP);
    chk({tag, "_pcd"},   pc_d,                32'h0);
    chk({tag, "_pc4d"},  pc_plus4_d,          32'h0);
    chk({tag, "_valid"}, {31'd0, valid_d},    32'h0);
    chk({tag, "_mis"},   {31'd0, misalign_f}, 32'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    pc_src_e = 2'b00; pc_target_e = 32'h0; alu_result_e = 32'h0;
    stall_f = 1'b0; stall_d = 1'b0;
    model_reset();

    // Reset held for 3 cycles, released away from the rising edge.
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Release edge itself is the first fetch edge; re-sync model by hand.
    m_instr = 32'hAAAA_0000; m_pcd = 32'h0; m_pc4d = 32'h4; m_valid = 1'b1; m_pc = 32'h4;
    chk("first_pcf",   pcf,              32'h4);
    chk("first_instr", instr_d,          32'hAAAA_0000);
    chk("first_valid", {31'd0, valid_d}, 32'h1);

    // Straight-line fetch up to PCF = 0x10.
    repeat (3) cycle(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("line_pcf", pcf, 32'h10);

    // Taken branch to 0x40.
    cycle(2'b01, 32'h40, 32'h0, 1'b0, 1'b0);
    chk("br_pcf",   pcf,              32'h40);
    chk("br_instr", instr_d,          NOP);
    chk("br_valid", {31'd0, valid_d}, 32'h0);
    cycle(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("br_pcd",   pc_d,             32'h40);
    chk("br_valid2", {31'd0, valid_d}, 32'h1);

    // JALR masking and misalign pulse.
    cycle(2'b10, 32'h0, 32'h0000_0123, 1'b0, 1'b0);
    chk("jalr_pcf", pcf,                 32'h122);
    chk("jalr_mis", {31'd0, misalign_f}, 32'h1);
    cycle(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("jalr_mis_clr", {31'd0, misalign_f}, 32'h0);
    cycle(2'b10, 32'h0, 32'h0000_0201, 1'b0, 1'b0);
    chk("jalr2_pcf", pcf,                 32'h200);
    chk("jalr2_mis", {31'd0, misalign_f}, 32'h0);

    // Reach PCF = 0x20 with a real instruction in IF/ID, then stall 2 cycles.
    cycle(2'b01, 32'h1C, 32'h0, 1'b0, 1'b0);
    cycle(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("pre_stall_pcf", pcf, 32'h20);
    repeat (2) cycle(2'b00, 32'h0, 32'h0, 1'b1, 1'b1);
    chk("stall_pcf", pcf,  32'h20);
    chk("stall_pcd", pc_d, 32'h1C);
    cycle(2'b01, 32'h80, 32'h0, 1'b1, 1'b1);
    chk("stall_redir_pcf",   pcf,              32'h80);
    chk("stall_redir_valid", {31'd0, valid_d}, 32'h0);
    chk("stall_redir_instr", instr_d,          NOP);

    // Random stall mixes with aligned branch targets and reserved code.
    for (int i = 0; i < 20; i++) begin
      logic [1:0] s;
      s = 2'($urandom_range(0, 3));
      cycle(s, {20'h0, 10'($urandom_range(0, 1023)), 2'b00},
            32'($urandom_range(0, 4095)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Wrap at the top of the address space under the reserved code.
    cycle(2'b01, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
    cycle(2'b11, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    chk("wrap_pcf",   pcf,              32'h0);
    chk("wrap_valid", {31'd0, valid_d}, 32'h1);
    chk("wrap_pcd",   pc_d,             32'hFFFF_FFFC);
    chk("wrap_pc4d",  pc_plus4_d,       32'h0);
    chk("wrap_instr", instr_d,          32'hFFFF_FFFC);

    // Asynchronous reset between edges while a redirect is pending.
    cycle(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    pc_src_e = 2'b01; pc_target_e = 32'h300;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("async");
    model_reset();
    pc_src_e = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_instr = 32'hAAAA_0000; m_pcd = 32'h0; m_pc4d = 32'h4; m_valid = 1'b1; m_pc = 32'h4;
    chk("post_rst_pcf",   pcf,     32'h4);
    chk("post_rst_instr", instr_d, 32'hAAAA_0000);
    cycle(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage RV32I pipeline, directly consuming the execute-stage PC select code (`PCSrcE`). It holds the program counter and computes the next PC from PC+4, the branch/JAL target, or the JALR target. It drives the instruction-memory address and registers the fetched instruction into the IF/ID pipeline register. It also honours hazard-unit stalls and squashes the wrong-path instruction on a taken redirect.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013: bubble instruction (`addi x0,x0,0`) written into IF/ID on reset or flush.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `PCSrcE` in 2: next-PC select from execute. 00 = PC+4, 01 = `PCTargetE`, 10 = JALR target, 11 = reserved (behaves as 00).
- `PCTargetE` in 32: branch/JAL target, computed as PCE+imm.
- `ALUResultE` in 32: JALR target before masking.
- `StallF` in 1: hazard unit request to hold the PC.
- `StallD` in 1: hazard unit request to hold IF/ID.
- `InstrF` in 32: instruction-memory read data for `PCF`, combinational.
- `PCF` out 32: current fetch PC; also the instruction-memory address.
- `InstrD` out 32: IF/ID instruction.
- `PCD` out 32: IF/ID PC.
- `PCPlus4D` out 32: IF/ID PC+4.
- `ValidD` out 1: IF/ID holds a real, non-bubble instruction.
- `MisalignF` out 1: registered pulse; the last redirect target had bits[1:0] != 0.

## Operation
- `PCPlus4F = PCF + 4`, computed modulo 2^32. 32'hFFFF_FFFC wraps to 0 with no flag.
- `PCNextF` by `PCSrcE`:
  - 01 → `PCTargetE`
  - 10 → `ALUResultE & 32'hFFFF_FFFE` (bit 0 cleared per the JALR definition)
  - 00 or 11 → `PCPlus4F`
- `RedirectE = (PCSrcE == 01) || (PCSrcE == 10)`.
- PC register update priority:
  1. `RedirectE` → load `PCNextF`. The redirect overrides `StallF`.
  2. else if `StallF` → hold.
  3. else → load `PCPlus4F`.
- IF/ID register update priority:
  1. `RedirectE` → load bubble: `InstrD = NOP_INSTR`, `PCD = 0`, `PCPlus4D = 0`, `ValidD = 0`. The flush overrides `StallD`.
  2. else if `StallD` → hold all four fields.
  3. else → load `{InstrF, PCF, PCPlus4F}` and set `ValidD = 1`.
- `StallF` without `StallD`: the IF/ID register loads the same `PCF` again. This is legal and the hazard unit is responsible for it; the block does not check it.
- `MisalignF`:
  - Set to 1 for exactly one cycle after an edge where `RedirectE` is 1 and `PCNextF[1:0] != 0`. Otherwise 0.
  - The PC still loads the unaligned value. Trapping is handled outside this block.
- No internal state beyond the PC register, the IF/ID register and the `MisalignF` flop.

## Timing
- Reset (`rst_n = 0`, asynchronous, takes effect immediately):
  - `PCF = RESET_PC`, `InstrD = NOP_INSTR`, `PCD = 0`, `PCPlus4D = 0`, `ValidD = 0`, `MisalignF = 0`.
- Release of `rst_n` is treated as synchronous to `clk`. The first fetch of `RESET_PC` is registered into IF/ID at the first rising edge after release.
- Reset asserted mid-redirect or mid-stall: every register returns to its reset value. A pending redirect is discarded.
- Latency: `PCSrcE` sampled at edge N → `PCF` equals the target after edge N. The target instruction reaches `InstrD` after edge N+1.
- Instructions lost per taken redirect: 2. One is squashed in IF/ID; the decode-stage instruction is flushed by the hazard unit (`FlushE`, external).
- `PCF` is purely registered with no combinational path from any input. `InstrF` reaches IF/ID only through the register.

## Test plan
- **Reset and straight-line fetch:** hold `rst_n = 0` for 3 cycles, then release with `PCSrcE = 00` and `InstrF = 32'hAAAA_0000 | PCF`. Expect `PCF` = 0, 4, 8, 12 on successive edges, `InstrD = 32'hAAAA_0000` one edge after `PCF = 0`, and `ValidD` rising on the first edge.
- **Taken branch:** at `PCF = 32'h10`, drive `PCSrcE = 01` and `PCTargetE = 32'h40` for one cycle. Expect:
  - next edge: `PCF = 32'h40`, `InstrD = NOP_INSTR`, `ValidD = 0`;
  - following edge: `PCD = 32'h40`, `ValidD = 1`.
- **JALR masking and misalign:** drive `PCSrcE = 10` with `ALUResultE = 32'h0000_0123`. Expect `PCF = 32'h0000_0122` and `MisalignF = 1` for exactly one cycle. Repeat with `ALUResultE = 32'h0000_0201`: expect `PCF = 32'h200` and `MisalignF = 0`.
- **Stall then redirect:** with `StallF = StallD = 1` for 2 cycles at `PCF = 32'h20`, expect `PCF` and IF/ID frozen. Then assert `StallF = StallD = 1` together with `PCSrcE = 01` and `PCTargetE = 32'h80`. Expect `PCF = 32'h80` and a bubble in IF/ID (the redirect wins).
- **Wrap and reserved code:** with `PCF = 32'hFFFF_FFFC` and `PCSrcE = 11`, expect `PCF = 0`, no flush, and `ValidD = 1`.
- **Asynchronous reset mid-run:** drop `rst_n` between clock edges while `PCSrcE = 01`. Expect `PCF = RESET_PC` and `ValidD = 0` immediately, with no clock edge required.
